// File: rtl/pl_rd_bram_seq.sv
// pl_rd_bram_seq: BRAM read sequencer streaming words over valid/ready; optional checksum via PL_RD_BRAM_SEQ_CHECKSUM_EN
module pl_rd_bram_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] cfg_sum
`endif
);
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 1;
  localparam int BYTES = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic start_ok, push, pop, done;
  logic [LEN_WIDTH-1:0] rem, out_rem;
  logic [ADDR_WIDTH-1:0] addr;
  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] mem [2**PW];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, inflight;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign start_ok  = state == IDLE && cfg_start;
  assign push      = vld[RD_LATENCY-1];
  assign pop       = m_tvalid && m_tready;
  assign m_tvalid  = count != '0;
  assign m_tdata   = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tlast   = m_tvalid && out_rem == LEN_WIDTH'(1);
  assign cfg_busy  = state == ISSUE || state == DRAIN;
  assign cfg_done  = done;
  assign bram_addr = addr;
  // reads still travelling through the BRAM latency pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld[i]);
  end
  // issue only when the FIFO is guaranteed room for every outstanding read
  always_comb bram_en = state == ISSUE && rem != '0 && (OW'(count) + OW'(inflight)) < OW'(DEPTH);
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_start) state_n = cfg_len == '0 ? DONE : ISSUE;
      ISSUE:   if (bram_en && rem == LEN_WIDTH'(1)) state_n = DRAIN;
      DRAIN:   if (pop && m_tlast) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // state register and sticky done flag
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state_n == DONE ? 1'b1 : start_ok ? 1'b0 : done;
    end
  end
  // address, issue and beat counters
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr    <= '0;
      rem     <= '0;
      out_rem <= '0;
    end else if (start_ok) begin
      addr    <= cfg_base_addr & ~ADDR_WIDTH'(BYTES - 1);
      rem     <= cfg_len;
      out_rem <= cfg_len;
    end else begin
      addr    <= bram_en ? addr + ADDR_WIDTH'(BYTES) : addr;
      rem     <= bram_en ? rem - LEN_WIDTH'(1) : rem;
      out_rem <= pop ? out_rem - LEN_WIDTH'(1) : out_rem;
    end
  end
  // read-data valid pipeline tagging returning words
  always_ff @(posedge ACLK) begin
    if (ARESET) vld <= '0;
    else begin
      vld[0] <= bram_en;
      for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
    end
  end
  // output FIFO storage
  always_ff @(posedge ACLK) if (push) mem[wr_ptr] <= bram_dout;
  // output FIFO pointers and occupancy
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? nxt(rd_ptr) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
  // running sum of accepted beats
  always_ff @(posedge ACLK) begin
    if (ARESET || start_ok) cfg_sum <= '0;
    else if (pop) cfg_sum <= cfg_sum + m_tdata;
  end
`endif
endmodule

// File: tb/tb_pl_rd_bram_seq.sv
// tb_pl_rd_bram_seq: directed self-checking bench for pl_rd_bram_seq
module tb_pl_rd_bram_seq;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 10;
  logic ACLK = 1'b0, ARESET = 1'b1, cfg_start = 1'b0, m_tready = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic cfg_busy, cfg_done, bram_en, m_tvalid, m_tlast;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] m_tdata;
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
  logic [DW-1:0] cfg_sum;
`endif
  logic [DW-1:0] ram [1024];
  int vectors = 0, fails = 0;
  logic [DW-1:0] beat_q[$];
  logic last_q[$];
  logic [AW-1:0] addr_q[$];
  int en_cnt = 0, stab_err = 0, outst = 0, max_out = 0;
  logic prev_stall = 1'b0, prev_rst = 1'b1, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;
  int b, e, a;
  pl_rd_bram_seq dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
    , .cfg_sum(cfg_sum)
`endif
  );
  always #5 ACLK = ~ACLK;
  // one-cycle-latency BRAM model
  always @(posedge ACLK) if (bram_en) bram_dout <= ram[bram_addr[AW-1:2]];
  // mid-cycle monitor: reads, beats, stability under stall, outstanding words
  always @(negedge ACLK) begin
    if (bram_en === 1'b1) begin
      en_cnt++;
      addr_q.push_back(bram_addr);
    end
    if (m_tvalid === 1'b1 && m_tready) begin
      beat_q.push_back(m_tdata);
      last_q.push_back(m_tlast);
    end
    if (prev_stall && !prev_rst && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l)) stab_err++;
    outst = ARESET ? 0 : outst + int'(bram_en === 1'b1) - int'(m_tvalid === 1'b1 && m_tready);
    if (outst > max_out) max_out = outst;
    prev_stall = m_tvalid === 1'b1 && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
    prev_rst = ARESET;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(cfg_busy), 64'd0);
    chk({tag, "_done"}, 64'(cfg_done), 64'd0);
    chk({tag, "_en"}, 64'(bram_en), 64'd0);
    chk({tag, "_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_tdata"}, 64'(m_tdata), 64'd0);
  endtask
  task automatic do_start(input logic [AW-1:0] base, input logic [LW-1:0] len);
    @(posedge ACLK); #1;
    cfg_start = 1'b1;
    cfg_base_addr = base;
    cfg_len = len;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask
  task automatic wait_done(input bit tog);
    int n = 0;
    while (cfg_done !== 1'b1 && n < 60) begin
      @(posedge ACLK); #1;
      if (tog) m_tready = ~m_tready;
      n++;
    end
    chk("wait_done", 64'(cfg_done), 64'd1);
  endtask
  task automatic check_run(input string tag, input int b0, input int n,
                           input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] ex [4];
    ex = '{e0, e1, e2, e3};
    chk($sformatf("%s_beats", tag), 64'(beat_q.size() - b0), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(beat_q[b0+i]), 64'(ex[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(last_q[b0+i]), 64'(i == n - 1));
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 8; i++) ram[i] = DW'(i + 1);
    ram[1022] = 32'h0000_000A;
    ram[1023] = 32'h0000_000B;
    ram[16] = 32'hFFFF_FFFF;
    ram[17] = 32'h0000_0002;
    repeat (3) @(posedge ACLK);
    #1;
    chk_idle("reset");
    ARESET = 1'b0;
    b = beat_q.size(); e = en_cnt;
    do_start(12'h000, 10'd4);
    chk("t1_en_first", 64'(bram_en), 64'd1);
    chk("t1_addr_first", 64'(bram_addr), 64'h000);
    chk("t1_busy", 64'(cfg_busy), 64'd1);
    chk("t1_done_low", 64'(cfg_done), 64'd0);
    chk("t1_tvalid_c0", 64'(m_tvalid), 64'd0);
    @(posedge ACLK); #1;
    chk("t1_tvalid_c1", 64'(m_tvalid), 64'd0);
    @(posedge ACLK); #1;
    chk("t1_tvalid_c2", 64'(m_tvalid), 64'd1);
    chk("t1_tdata_c2", 64'(m_tdata), 64'd1);
    wait_done(1'b0);
    chk("t1_busy_end", 64'(cfg_busy), 64'd0);
    check_run("t1", b, 4, 32'h1, 32'h2, 32'h3, 32'h4);
    chk("t1_en_count", 64'(en_cnt - e), 64'd4);
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
    chk("t1_sum", 64'(cfg_sum), 64'hA);
`endif
    b = beat_q.size(); e = en_cnt;
    do_start(12'h000, 10'd4);
    chk("t2_done_cleared", 64'(cfg_done), 64'd0);
    wait_done(1'b1);
    m_tready = 1'b1;
    check_run("t2", b, 4, 32'h1, 32'h2, 32'h3, 32'h4);
    chk("t2_en_count", 64'(en_cnt - e), 64'd4);
    chk("t2_max_outstanding", 64'(max_out <= 3), 64'd1);
    b = beat_q.size(); a = addr_q.size();
    do_start(12'hFF8, 10'd4);
    wait_done(1'b0);
    chk("t3_addr0", 64'(addr_q[a]), 64'hFF8);
    chk("t3_addr1", 64'(addr_q[a+1]), 64'hFFC);
    chk("t3_addr2", 64'(addr_q[a+2]), 64'h000);
    chk("t3_addr3", 64'(addr_q[a+3]), 64'h004);
    check_run("t3", b, 4, 32'hA, 32'hB, 32'h1, 32'h2);
    b = beat_q.size(); a = addr_q.size();
    do_start(12'h00A, 10'd1);
    wait_done(1'b0);
    chk("t3b_addr_align", 64'(addr_q[a]), 64'h008);
    check_run("t3b", b, 1, 32'h3, 32'h0, 32'h0, 32'h0);
    m_tready = 1'b0;
    b = beat_q.size(); e = en_cnt;
    do_start(12'h000, 10'd8);
    repeat (2) begin @(posedge ACLK); #1; end
    cfg_start = 1'b1;
    cfg_base_addr = 12'h100;
    cfg_len = 10'd2;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    repeat (4) begin @(posedge ACLK); #1; end
    chk("t5_en_stalled", 64'(en_cnt - e), 64'd3);
    chk("t5_addr_kept", 64'(bram_addr), 64'h00C);
    chk("t5_busy", 64'(cfg_busy), 64'd1);
    chk("t5_tvalid", 64'(m_tvalid), 64'd1);
    chk("t5_tdata", 64'(m_tdata), 64'd1);
    chk("t5_tlast", 64'(m_tlast), 64'd0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk_idle("t5_reset");
    chk("t5_no_beats", 64'(beat_q.size() - b), 64'd0);
    b = beat_q.size(); e = en_cnt;
    do_start(12'h000, 10'd0);
    chk("t4_done_next", 64'(cfg_done), 64'd1);
    chk("t4_busy", 64'(cfg_busy), 64'd0);
    chk("t4_en", 64'(bram_en), 64'd0);
    repeat (3) begin @(posedge ACLK); #1; end
    chk("t4_en_count", 64'(en_cnt - e), 64'd0);
    chk("t4_beats", 64'(beat_q.size() - b), 64'd0);
    chk("t4_tvalid", 64'(m_tvalid), 64'd0);
    chk("t4_done_held", 64'(cfg_done), 64'd1);
    m_tready = 1'b1;
    b = beat_q.size(); e = en_cnt;
    do_start(12'h000, 10'd2);
    wait_done(1'b0);
    check_run("t5_fresh", b, 2, 32'h1, 32'h2, 32'h0, 32'h0);
    chk("t5_fresh_en", 64'(en_cnt - e), 64'd2);
    b = beat_q.size();
    do_start(12'h040, 10'd2);
    wait_done(1'b0);
    check_run("t6", b, 2, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);
`ifdef PL_RD_BRAM_SEQ_CHECKSUM_EN
    chk("t6_sum", 64'(cfg_sum), 64'h1);
`endif
    chk("stall_stability", 64'(stab_err), 64'd0);
    chk("max_outstanding", 64'(max_out <= 3), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
